tea_cbc_ctrl: RTL and testbench
===============================

// Module: tea_cbc_ctrl
// PURPOSE
// - CBC chaining controller directly upstream of the TEA cipher/decipher core.
// - Accepts a stream of 64-bit blocks on a valid/ready handshake and applies CBC chaining (XOR with IV or previous block).
// - Drives the core's start/data inputs, captures its result on done, and presents the result on a valid/ready output.
// - The key-fetch path (key address/word) stays between the core and the key store; this block does not touch it.
// PARAMETERS
// - WORD_SIZE  32    half-block width; a block is {V0,V1} = 2*WORD_SIZE bits
// - MAX_WAIT   1024  cycles allowed in RUN before timeout
// - CNT_W      11    width of the wait counter; must satisfy 2**CNT_W > MAX_WAIT
// PORTS
// - clk             in   1    single clock, rising edge
// - rst             in   1    asynchronous, active-low reset
// - iMode           in   1    0 = CBC encrypt, 1 = CBC decrypt; sampled only with iIVLoad
// - iIVLoad         in   1    1-cycle pulse: load iIV0/iIV1 into the chain register and latch iMode; honoured only in IDLE
// - iIV0, iIV1      in   WS   initialisation vector
// - iValid          in   1    input block valid
// - oReady          out  1    input block accepted when iValid && oReady
// - iD0, iD1        in   WS   input block (plaintext when encrypting, ciphertext when decrypting)
// - oV0, oV1        out  WS   block to core
// - oStartCipher    out  1    core start, encrypt; held high until done
// - oStartDecipher  out  1    core start, decrypt; held high until done
// - iC0, iC1        in   WS   core result
// - iDone           in   1    core done
// - oValid          out  1    output block valid; held until accepted
// - iReady          in   1    output block consumed when oValid && iReady
// - oQ0, oQ1        out  WS   output block
// - oError          out  1    sticky timeout flag; cleared by iIVLoad or reset
// BEHAVIOUR
// - Reset values: all outputs 0; chain register 0; mode 0; state IDLE.
// - oReady = 1 only in IDLE while no output is pending.
// - FSM states: IDLE, RUN, OUT, GAP.
// - IDLE:
//   - iIVLoad sets chain = {iIV0,iIV1}, mode = iMode, oError = 0.
//   - Else if iValid, accept the block and move to RUN.
//   - iIVLoad and iValid in the same cycle: only the IV load takes effect, and oReady is deasserted that cycle.
// - Input latch on accept:
//   - Encrypt: {oV0,oV1} = {iD0,iD1} ^ chain.
//   - Decrypt: {oV0,oV1} = {iD0,iD1}, and {iD0,iD1} is also saved as the next chain value.
// - RUN:
//   - oStartCipher (mode 0) or oStartDecipher (mode 1) is held high; exactly one is high, never both.
//   - oV0/oV1 are stable for the whole state.
//   - Wait counter increments every cycle.
//   - On the first cycle with iDone = 1: capture the result, drop start the next cycle, and go to OUT.
//     - Encrypt: {oQ0,oQ1} = {iC0,iC1}; chain = {iC0,iC1}.
//     - Decrypt: {oQ0,oQ1} = {iC0,iC1} ^ old chain; chain = saved input block.
//   - If the counter reaches MAX_WAIT without iDone: drop start, set oError, go to GAP, leave chain unchanged, produce no output.
// - OUT: oValid = 1 and oQ is held until iReady; on the handshake go to GAP. Back-to-back throughput is bounded by the core anyway.
// - GAP: one cycle with both starts low, so the core's key loader and round counter re-arm; then go to IDLE.
// - Latency from accept to oValid = core latency + 1 cycle.
// - The counter is cleared on entry to RUN and saturates; it never wraps.
// - iDone outside RUN is ignored.
// - Asynchronous reset mid-operation: immediate return to IDLE, starts low, pending output discarded, chain = 0.
// - All XORs are full 2*WORD_SIZE bits. There is no arithmetic in this block beyond the counter.
// TESTING
// 1. Key all-zero, IV=0, encrypt, input block 0 -> oQ = 41EA3A0A_94BAA940; oStartCipher high only during RUN.
// 2. Same setup, second block 0 -> core sees oV = 41EA3A0A_94BAA940; oQ = TEA(0, that value) from the bench model.
// 3. Decrypt the two ciphertexts from tests 1-2 with IV=0 -> oQ = 0, then 0; oStartDecipher used, never oStartCipher.
// 4. Hold iReady=0 for 20 cycles after oValid -> oQ stable, oReady=0, no new accept; release -> GAP, then IDLE.
// 5. Stub core never asserts iDone, MAX_WAIT=16 -> start drops after 16 cycles, oError=1, no oValid; iIVLoad clears oError.
// 6. Assert rst low during RUN -> starts and oValid go 0 asynchronously; after release the next block uses chain = 0.

Source files
------------

// File: rtl/tea_cbc_ctrl.sv
// CBC chaining front-end for the TEA cipher/decipher core: XORs the chain value
// around the core, drives its start/data inputs, and hands results out on valid/ready.
module tea_cbc_ctrl #(
    parameter int WORD_SIZE = 32,
    parameter int MAX_WAIT  = 1024,
    parameter int CNT_W     = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iMode,
    input  logic                 iIVLoad,
    input  logic [WORD_SIZE-1:0] iIV0,
    input  logic [WORD_SIZE-1:0] iIV1,
    input  logic                 iValid,
    output logic                 oReady,
    input  logic [WORD_SIZE-1:0] iD0,
    input  logic [WORD_SIZE-1:0] iD1,
    output logic [WORD_SIZE-1:0] oV0,
    output logic [WORD_SIZE-1:0] oV1,
    output logic                 oStartCipher,
    output logic                 oStartDecipher,
    input  logic [WORD_SIZE-1:0] iC0,
    input  logic [WORD_SIZE-1:0] iC1,
    input  logic                 iDone,
    output logic                 oValid,
    input  logic                 iReady,
    output logic [WORD_SIZE-1:0] oQ0,
    output logic [WORD_SIZE-1:0] oQ1,
    output logic                 oError
);
    localparam int BW = 2 * WORD_SIZE;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OUT = 2'd2, GAP = 2'd3} state_t;

    state_t           state, stateNext;
    logic [BW-1:0]    chain, blkV, savedIn, resQ;
    logic [BW-1:0]    inBlk, coreRes;
    logic             modeDec, readyEn, errFlag;
    logic             ivLoad, accept, timeout;
    logic [CNT_W-1:0] waitCnt;

    assign inBlk   = {iD0, iD1};
    assign coreRes = {iC0, iC1};

    // readyEn keeps oReady low while reset is held, so every output reads 0 in reset.
    assign ivLoad  = (state == IDLE) && iIVLoad;
    assign oReady  = (state == IDLE) && readyEn && !iIVLoad;
    assign accept  = oReady && iValid;
    assign timeout = (waitCnt == CNT_W'(MAX_WAIT - 1));

    assign oV0            = blkV[BW-1:WORD_SIZE];
    assign oV1            = blkV[WORD_SIZE-1:0];
    assign oQ0            = resQ[BW-1:WORD_SIZE];
    assign oQ1            = resQ[WORD_SIZE-1:0];
    assign oStartCipher   = (state == RUN) && !modeDec;
    assign oStartDecipher = (state == RUN) && modeDec;
    assign oValid         = (state == OUT);
    assign oError         = errFlag;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (accept) stateNext = RUN;
            RUN: begin
                if (iDone)        stateNext = OUT;
                else if (timeout) stateNext = GAP;
            end
            OUT:  if (iReady) stateNext = GAP;
            GAP:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            readyEn <= 1'b0;
            chain   <= '0;
            blkV    <= '0;
            savedIn <= '0;
            resQ    <= '0;
            modeDec <= 1'b0;
            errFlag <= 1'b0;
            waitCnt <= '0;
        end else begin
            state   <= stateNext;
            readyEn <= 1'b1;
            if (ivLoad) begin
                chain   <= {iIV0, iIV1};
                modeDec <= iMode;
                errFlag <= 1'b0;
            end
            if (accept) begin
                blkV    <= modeDec ? inBlk : (inBlk ^ chain);
                savedIn <= inBlk;
                waitCnt <= '0;
            end
            if (state == RUN) begin
                if (iDone) begin
                    // Decrypt un-chains with the old chain, then chains on the ciphertext.
                    resQ  <= modeDec ? (coreRes ^ chain) : coreRes;
                    chain <= modeDec ? savedIn : coreRes;
                end else if (timeout) begin
                    errFlag <= 1'b1;
                end else if (waitCnt != '1) begin
                    waitCnt <= waitCnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_tea_cbc_ctrl.sv
// Bench for tea_cbc_ctrl: behavioural TEA core and a CBC reference model
// (chain value + mode) predicting every block the controller sends and returns.
module tb_tea_cbc_ctrl;
    logic        clk;
    logic        rst;
    logic        iMode, iIVLoad, iValid, iDone, iReady;
    logic [31:0] iIV0, iIV1, iD0, iD1, iC0, iC1;
    logic        oReady, oStartCipher, oStartDecipher, oValid, oError;
    logic [31:0] oV0, oV1, oQ0, oQ1;

    int checks;
    int failures;

    logic [127:0] key;
    int           coreLat;
    bit           stubCore;
    bit           strayDone;
    logic [63:0]  mChain;
    bit           mDec;

    tea_cbc_ctrl #(.WORD_SIZE(32), .MAX_WAIT(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .iMode(iMode), .iIVLoad(iIVLoad), .iIV0(iIV0), .iIV1(iIV1),
        .iValid(iValid), .oReady(oReady), .iD0(iD0), .iD1(iD1), .oV0(oV0), .oV1(oV1),
        .oStartCipher(oStartCipher), .oStartDecipher(oStartDecipher), .iC0(iC0), .iC1(iC1),
        .iDone(iDone), .oValid(oValid), .iReady(iReady), .oQ0(oQ0), .oQ1(oQ1), .oError(oError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] teaEnc(input logic [63:0] v, input logic [127:0] k);
        logic [31:0] y, z, s;
        y = v[63:32]; z = v[31:0]; s = 32'h0;
        for (int i = 0; i < 32; i++) begin
            s = s + 32'h9E3779B9;
            y = y + (((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]));
            z = z + (((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]));
        end
        return {y, z};
    endfunction

    function automatic logic [63:0] teaDec(input logic [63:0] v, input logic [127:0] k);
        logic [31:0] y, z, s;
        y = v[63:32]; z = v[31:0]; s = 32'hC6EF3720;
        for (int i = 0; i < 32; i++) begin
            z = z - (((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]));
            y = y - (((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]));
            s = s - 32'h9E3779B9;
        end
        return {y, z};
    endfunction

    // Behavioural core: sees start, answers after coreLat cycles with a one-cycle done.
    initial begin
        logic [63:0] res;
        iDone = 1'b0; iC0 = '0; iC1 = '0;
        forever begin
            @(posedge clk); #1;
            iDone = 1'b0;
            if (!stubCore && rst && (oStartCipher || oStartDecipher)) begin
                res = oStartCipher ? teaEnc({oV0, oV1}, key) : teaDec({oV0, oV1}, key);
                repeat (coreLat - 1) begin @(posedge clk); #1; end
                {iC0, iC1} = res; iDone = 1'b1;
                @(posedge clk); #1;
                iDone = 1'b0; iC0 = $urandom; iC1 = $urandom;
            end else if (strayDone) begin
                iDone = 1'b1; iC0 = $urandom; iC1 = $urandom;
            end
        end
    end

    task automatic ivLoad(input logic [63:0] iv, input bit mode, input bit withValid);
        @(posedge clk); #1;
        iIVLoad = 1'b1; {iIV0, iIV1} = iv; iMode = mode;
        if (withValid) begin iValid = 1'b1; iD0 = $urandom; iD1 = $urandom; end
        @(negedge clk);
        if (withValid) chk("ivCollisionReady", oReady, 0);
        @(posedge clk); #1;
        iIVLoad = 1'b0; iValid = 1'b0;
        mChain = iv; mDec = mode;
        @(negedge clk);
        chk("ivClearsError", oError, 0);
        if (withValid) chk("ivCollisionNoAccept", oReady, 1);
    endtask

    task automatic sendBlock(input logic [63:0] d, output bit ok);
        ok = 1'b0;
        @(posedge clk); #1;
        iValid = 1'b1; {iD0, iD1} = d;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (oReady) begin
                @(posedge clk); #1;
                ok = 1'b1;
            end
        end
        iValid = 1'b0; iD0 = $urandom; iD1 = $urandom;
    endtask

    task automatic doBlock(input logic [63:0] d, input int rdyDelay, input bit probe,
                           output logic [63:0] q);
        logic [63:0] xV, qExp;
        bit ok, got, startBad, holdBad;
        int lat;
        if (!mDec) begin xV = d ^ mChain; qExp = teaEnc(xV, key); mChain = qExp; end
        else begin xV = d; qExp = teaDec(d, key) ^ mChain; mChain = d; end
        q = '0; got = 1'b0; lat = 0; startBad = 1'b0; holdBad = 1'b0;
        sendBlock(d, ok);
        chk("accept", ok, 1);
        if (!ok) return;
        for (int n = 1; n <= 40 && !got; n++) begin
            @(negedge clk);
            if (n == 1) chk("coreInput", {oV0, oV1}, xV);
            if (oStartCipher && oStartDecipher) startBad = 1'b1;
            if ((mDec ? oStartCipher : oStartDecipher)) startBad = 1'b1;
            if ((oStartCipher || oStartDecipher) && {oV0, oV1} !== xV) startBad = 1'b1;
            if (oValid) begin got = 1'b1; lat = n; end
        end
        chk("validSeen", got, 1);
        chk("latency", lat, coreLat + 1);
        chk("startUse", startBad, 0);
        if (!got) return;
        q = {oQ0, oQ1};
        chk("oQ", q, qExp);
        if (probe) begin
            @(posedge clk); #1;
            iValid = 1'b1; iD0 = $urandom; iD1 = $urandom; strayDone = 1'b1;
        end
        for (int i = 0; i < rdyDelay; i++) begin
            @(negedge clk);
            if ({oQ0, oQ1} !== q || !oValid || oReady || oStartCipher || oStartDecipher)
                holdBad = 1'b1;
        end
        chk("outputHold", holdBad, 0);
        @(posedge clk); #1;
        iValid = 1'b0; strayDone = 1'b0; iReady = 1'b1;
        @(posedge clk); #1;
        iReady = 1'b0;
        @(negedge clk);
        chk("gapState", {oValid, oReady, oStartCipher, oStartDecipher}, 0);
        @(negedge clk);
        chk("backToIdle", oReady, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] c1, c2, q, d, iv;
        bit ok, sawValid;
        int cnt;
        checks = 0; failures = 0;
        rst = 1'b0;
        iMode = 0; iIVLoad = 0; iIV0 = 0; iIV1 = 0; iValid = 0; iD0 = 0; iD1 = 0; iReady = 0;
        key = '0; coreLat = 3; stubCore = 1'b0; strayDone = 1'b0; mChain = '0; mDec = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rstReady", oReady, 0);
        chk("rstStarts", {oStartCipher, oStartDecipher, oValid, oError}, 0);
        chk("rstV", {oV0, oV1}, 0);
        chk("rstQ", {oQ0, oQ1}, 0);
        @(posedge clk); #1; rst = 1'b1;

        // Zero key, zero IV, encrypt two zero blocks (load collides with a valid block)
        ivLoad(64'h0, 1'b0, 1'b1);
        doBlock(64'h0, 0, 1'b0, c1);
        chk("teaVector", c1, 64'h41EA3A0A_94BAA940);
        coreLat = 5;
        doBlock(64'h0, 1, 1'b0, c2);

        // Decrypt them back with the same IV
        ivLoad(64'h0, 1'b1, 1'b0);
        doBlock(c1, 0, 1'b0, q);
        chk("decBlock1", q, 0);
        doBlock(c2, 2, 1'b0, q);
        chk("decBlock2", q, 0);

        // Long output stall with a new block offered and stray done pulses
        coreLat = 2;
        doBlock({$urandom, $urandom}, 20, 1'b1, q);

        // Timeout: core never answers
        iv = {$urandom, $urandom};
        ivLoad(iv, 1'b0, 1'b0);
        stubCore = 1'b1;
        d = {$urandom, $urandom};
        sendBlock(d, ok);
        chk("toAccept", ok, 1);
        cnt = 0; sawValid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) chk("toCoreInput", {oV0, oV1}, d ^ iv);
            if (oValid) sawValid = 1'b1;
            if (oStartCipher) cnt++;
            else break;
        end
        chk("toStartCycles", cnt, 16);
        chk("toError", oError, 1);
        chk("toNoValid", sawValid, 0);
        stubCore = 1'b0;
        coreLat = 4;
        doBlock({$urandom, $urandom}, 0, 1'b0, q);
        chk("errorSticky", oError, 1);
        ivLoad({$urandom, $urandom}, 1'b1, 1'b0);

        // Asynchronous reset while the core is running
        stubCore = 1'b1;
        sendBlock({$urandom, $urandom}, ok);
        repeat (3) @(negedge clk);
        chk("preRstStart", oStartCipher | oStartDecipher, 1);
        #2 rst = 1'b0;
        #1;
        chk("asyncRstOut", {oStartCipher, oStartDecipher, oValid, oReady}, 0);
        chk("asyncRstV", {oV0, oV1}, 0);
        @(posedge clk); #1; rst = 1'b1;
        stubCore = 1'b0; mChain = '0; mDec = 1'b0;
        doBlock({$urandom, $urandom}, 0, 1'b0, q);

        // Randomized traffic with a random key
        key = {$urandom, $urandom, $urandom, $urandom};
        for (int b = 0; b < 40; b++) begin
            if (b % 8 == 0)
                ivLoad({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            coreLat = $urandom_range(1, 10);
            doBlock({$urandom, $urandom}, $urandom_range(0, 3), 1'($urandom_range(0, 1)), q);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
